// File: rtl/mtx_kbd_pkg.sv
// Shared keyboard-path types and ps2_key bit positions for the rememotech key path.
package mtx_kbd_pkg;

    localparam int KEY_TGL_BIT   = 10;
    localparam int KEY_PRESS_BIT = 9;
    localparam int KEY_EXT_BIT   = 8;

    typedef struct packed {
        logic       pressed;
        logic       ext;
        logic [7:0] code;
    } key_evt_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EMIT,
        ST_GAP
    } kq_state_t;

    // Takes the low ten bits of the mist_io word; the toggle bit is handled separately.
    function automatic key_evt_t key_evt_from_ps2(input logic [9:0] key);
        key_evt_t evt;
        evt.pressed = key[KEY_PRESS_BIT];
        evt.ext     = key[KEY_EXT_BIT];
        evt.code    = key[7:0];
        return evt;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO; pointers carry an extra MSB so full and empty are distinguishable.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_en;
    logic             rd_en;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level   = wr_ptr_q - rd_ptr_q;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
    assign rd_en   = pop && !empty;
    assign wr_en   = push && (!full || rd_en);

    // NOTE: every _d gets its default first, so no path through this block can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    // NOTE: state updates are non-blocking so every flop samples pre-edge values.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk_sys) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/ps2_key_queue.sv
// Queues ps2_key toggle events and replays them to the core one strobe at a time,
// holding the line idle for GAP_CYCLES after each strobe so the matrix scanner keeps up.
module ps2_key_queue
    import mtx_kbd_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int GAP_CYCLES = 65536
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic [10:0]            ps2_key,
    output logic                   key_ready,
    output logic                   key_stroke,
    output logic [9:0]             key_code,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] level
);

    localparam int CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    kq_state_t        state_q, state_d;
    logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             old_tgl_q, old_tgl_d;
    logic             overflow_q, overflow_d;
    logic             key_ready_q, key_ready_d;
    logic             key_stroke_q, key_stroke_d;
    logic [9:0]       key_code_q, key_code_d;

    logic             evt;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    key_evt_t         wr_evt;
    key_evt_t         rd_evt;

    assign evt       = ps2_key[KEY_TGL_BIT] ^ old_tgl_q;
    assign wr_evt    = key_evt_from_ps2(ps2_key[9:0]);
    assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;
    assign old_tgl_d = ps2_key[KEY_TGL_BIT];

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(key_evt_t))
    ) u_fifo (
        .clk_sys (clk_sys),
        .reset   (reset),
        .push    (evt),
        .wr_data (wr_evt),
        .pop     (fifo_pop),
        .rd_data (rd_evt),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    always_comb begin
        state_d      = state_q;
        gap_cnt_d    = gap_cnt_q;
        key_ready_d  = 1'b0;
        key_stroke_d = key_stroke_q;
        key_code_d   = key_code_q;
        // A full FIFO still takes the new event when the FSM pops in the same cycle.
        overflow_d   = overflow_q | (evt & fifo_full & ~fifo_pop);

        case (state_q)
            ST_IDLE: begin
                if (fifo_pop) begin
                    key_stroke_d = rd_evt.pressed;
                    key_code_d   = {1'b0, rd_evt.ext, rd_evt.code};
                    state_d      = ST_EMIT;
                end
            end
            ST_EMIT: begin
                key_ready_d = 1'b1;
                gap_cnt_d   = GAP_LOAD;
                state_d     = ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) state_d = ST_IDLE;
                else                 gap_cnt_d = gap_cnt_q - CNT_ONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // old_tgl follows the toggle bit even in reset, so releasing reset never fakes an event.
    always_ff @(posedge clk_sys) begin
        old_tgl_q <= old_tgl_d;
        if (reset) begin
            state_q      <= ST_IDLE;
            gap_cnt_q    <= '0;
            overflow_q   <= 1'b0;
            key_ready_q  <= 1'b0;
            key_stroke_q <= 1'b0;
            key_code_q   <= '0;
        end else begin
            state_q      <= state_d;
            gap_cnt_q    <= gap_cnt_d;
            overflow_q   <= overflow_d;
            key_ready_q  <= key_ready_d;
            key_stroke_q <= key_stroke_d;
            key_code_q   <= key_code_d;
        end
    end

    assign key_ready  = key_ready_q;
    assign key_stroke = key_stroke_q;
    assign key_code   = key_code_q;
    assign overflow   = overflow_q;

endmodule
